// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: derives per-stage stall and flush strobes from load-use,
// taken-branch and data-memory wait conditions, with a sticky memory-timeout fault.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_read1_e_i,
    input  logic             id_read2_e_i,
    input  logic             ex_MemRead_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_stall_o,
    output logic             idex_flush_o,
    output logic             exmem_stall_o,
    output logic             memwb_flush_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {
        StRun = 1'b0,
        StErr = 1'b1
    } state_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_busy;
    logic             load_use;

    assign mem_busy = mem_req_i & ~mem_ready_i;
    assign load_use = ex_MemRead_i & (ex_rd_i != 5'd0) &
                      ((id_read1_e_i & (id_rs1_i == ex_rd_i)) |
                       (id_read2_e_i & (id_rs2_i == ex_rd_i)));

    // Strobes are forced low while reset is asserted, independent of state.
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_stall_o = 1'b0;
        memwb_flush_o = 1'b0;
        if (rst_i) begin
            if (state_q == StErr || mem_busy) begin
                pc_stall_o    = 1'b1;
                ifid_stall_o  = 1'b1;
                idex_stall_o  = 1'b1;
                exmem_stall_o = 1'b1;
                memwb_flush_o = 1'b1;
            end else if (ex_branch_taken_i) begin
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
            end else if (load_use) begin
                pc_stall_o    = 1'b1;
                ifid_stall_o  = 1'b1;
                idex_flush_o  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (state_q == StRun) begin
            if (mem_busy) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_q == WaitLast) begin
                    state_d = StErr;
                end
            end else begin
                wait_cnt_d = 8'd0;
            end
        end

        if (pc_stall_o && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        // ifid_flush_o only fires for a taken branch in RUN, so it marks a flush event.
        if (ifid_flush_o && flush_cnt_q != {CNT_W{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err_o       = (state_q == StErr);
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand sequences for wait, timeout,
// saturation and asynchronous reset.
module tb_hazard_ctrl;

    localparam int unsigned CntW   = 4;
    localparam int          CntMax = 15;

    // Strobe order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush
    localparam logic [6:0] SNone = 7'b0000000;
    localparam logic [6:0] SMem  = 7'b1101011;
    localparam logic [6:0] SBr   = 7'b0010100;
    localparam logic [6:0] SLu   = 7'b1100100;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       r1e;
        logic       r2e;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_r1e = 1'b0, id_r2e = 1'b0, ex_mr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;

    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, err;
    logic [CntW-1:0] stall_cnt, flush_cnt;
    logic u1_pc_stall, u1_ifid_stall, u1_ifid_flush, u1_idex_stall, u1_idex_flush;
    logic u1_exmem_stall, u1_memwb_flush, u1_err;
    logic [15:0] u1_stall_cnt, u1_flush_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CntW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_read1_e_i(id_r1e), .id_read2_e_i(id_r2e),
        .ex_MemRead_i(ex_mr), .ex_rd_i(ex_rd), .ex_branch_taken_i(br),
        .mem_req_i(req), .mem_ready_i(rdy),
        .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
        .idex_stall_o(idex_stall), .idex_flush_o(idex_flush), .exmem_stall_o(exmem_stall),
        .memwb_flush_o(memwb_flush), .err_o(err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    hazard_ctrl #(.MEM_TIMEOUT(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_read1_e_i(id_r1e), .id_read2_e_i(id_r2e),
        .ex_MemRead_i(ex_mr), .ex_rd_i(ex_rd), .ex_branch_taken_i(br),
        .mem_req_i(req), .mem_ready_i(rdy),
        .pc_stall_o(u1_pc_stall), .ifid_stall_o(u1_ifid_stall), .ifid_flush_o(u1_ifid_flush),
        .idex_stall_o(u1_idex_stall), .idex_flush_o(u1_idex_flush),
        .exmem_stall_o(u1_exmem_stall), .memwb_flush_o(u1_memwb_flush), .err_o(u1_err),
        .stall_cnt_o(u1_stall_cnt), .flush_cnt_o(u1_flush_cnt)
    );

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic r1e,
                                input logic r2e, input logic mr, input logic [4:0] rd,
                                input logic b, input logic rq, input logic rd_y,
                                input logic [6:0] e);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.r1e = r1e; v.r2e = r2e; v.mr = mr; v.rd = rd;
        v.br = b; v.req = rq; v.rdy = rd_y; v.exp = e;
        return v;
    endfunction

    function automatic logic [6:0] strobes();
        return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
                memwb_flush};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_r1e = v.r1e; id_r2e = v.r2e;
        ex_mr = v.mr; ex_rd = v.rd; br = v.br; req = v.req; rdy = v.rdy;
    endtask

    // One clock cycle: drive at negedge, check strobes mid-cycle, check counters after posedge.
    task automatic step(input vec_t v, input string name);
        logic [6:0] e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v.exp);
        #1;
        e = exp_q.pop_front();
        chk({name, " strobes"}, int'(strobes()), int'(e));
        @(posedge clk);
        #1;
        if (e[6] && exp_stall < CntMax) exp_stall++;
        if (e[4] && exp_flush < CntMax) exp_flush++;
        chk({name, " stall_cnt"}, int'(stall_cnt), exp_stall);
        chk({name, " flush_cnt"}, int'(flush_cnt), exp_flush);
    endtask

    // Asserts reset between clock edges with the current inputs still applied.
    task automatic do_reset(input string name);
        #2;
        rst_i = 1'b0;
        #1;
        chk({name, " strobes"}, int'(strobes()), 0);
        chk({name, " err"}, int'(err), 0);
        chk({name, " u1 err"}, int'(u1_err), 0);
        chk({name, " stall_cnt"}, int'(stall_cnt), 0);
        chk({name, " flush_cnt"}, int'(flush_cnt), 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, SNone));
        exp_stall = 0;
        exp_flush = 0;
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = mk(0, 5, 0, 1, 1, 5, 0, 0, 0, SLu);    // load-use on rs2
        tbl[1] = mk(0, 5, 0, 0, 1, 5, 0, 0, 0, SNone);  // rs2 not read
        tbl[2] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, SNone);  // load to x0
        tbl[3] = mk(7, 0, 1, 0, 1, 7, 0, 0, 0, SLu);    // load-use on rs1
        tbl[4] = mk(7, 0, 1, 0, 0, 7, 0, 0, 0, SNone);  // not a load
        tbl[5] = mk(0, 5, 0, 1, 1, 5, 1, 0, 0, SBr);    // branch beats load-use
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, SNone);  // memory ready at once
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, SMem);   // busy beats branch
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, SNone);

        repeat (2) @(posedge clk);
        #1;
        chk("reset strobes", int'(strobes()), 0);
        chk("reset err", int'(err), 0);
        chk("reset stall_cnt", int'(stall_cnt), 0);
        chk("reset flush_cnt", int'(flush_cnt), 0);
        @(negedge clk);
        rst_i = 1'b1;

        for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("vec%0d", i));
        chk("vec err", int'(err), 0);
        chk("timeout1 err", int'(u1_err), 1);

        // Memory wait with a branch pending throughout.
        do_reset("rst_a");
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, SMem), "wait busy");
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, SBr), "wait done");
        chk("wait stall_cnt abs", int'(stall_cnt), 3);
        chk("wait flush_cnt abs", int'(flush_cnt), 1);
        chk("wait err", int'(err), 0);

        // Timeout after four consecutive busy cycles, then sticky fault.
        do_reset("rst_b");
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, SMem), "tmo busy");
        chk("tmo err early", int'(err), 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, SMem), "tmo last");
        chk("tmo err", int'(err), 1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, SMem), "err ready");
        step(mk(0, 5, 0, 1, 1, 5, 1, 0, 0, SMem), "err branch");
        chk("err sticky", int'(err), 1);
        do_reset("rst_err");
        step(mk(0, 5, 0, 1, 1, 5, 0, 0, 0, SLu), "post-err lu");
        chk("post-err err", int'(err), 0);

        // Stall counter saturation.
        do_reset("rst_c");
        for (int i = 0; i < 20; i++) step(mk(0, 5, 0, 1, 1, 5, 0, 0, 0, SLu), "sat lu");
        chk("sat stall_cnt", int'(stall_cnt), CntMax);

        // Asynchronous reset in the middle of a memory wait.
        do_reset("rst_d");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, SMem), "mid busy");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, SMem), "mid busy2");
        do_reset("rst_mid");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, SNone), "after mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
